// File: rtl/rifl_rx_frame_check_if.sv
// rtl/rifl_rx_frame_check_if.sv - beat stream in, checked/descrambled stream and status out
interface rifl_rx_frame_check_if #(
  parameter int DWIDTH        = 64,
  parameter int ERR_CNT_WIDTH = 16
);
  logic                     sof;
  logic [DWIDTH-1:0]        data_in;
  logic                     sof_out;
  logic [DWIDTH-1:0]        data_out;
  logic                     crc_valid;
  logic                     crc_err;
  logic                     frame_abort;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  modport master (
    output sof, data_in,
    input  sof_out, data_out, crc_valid, crc_err, frame_abort, err_cnt
  );

  modport slave (
    input  sof, data_in,
    output sof_out, data_out, crc_valid, crc_err, frame_abort, err_cnt
  );
endinterface

// File: rtl/rifl_rx_frame_check.sv
// rtl/rifl_rx_frame_check.sv - RIFL RX frame CRC check and self-sync descrambler
module rifl_rx_frame_check #(
  parameter int                   FRAME_WIDTH   = 256,
  parameter int                   DWIDTH        = 64,
  parameter int                   CRC_WIDTH     = 12,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY      = 12'h80F,
  parameter int                   N1            = 13,
  parameter int                   N2            = 33,
  parameter int                   ERR_CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  rifl_rx_frame_check_if.slave bus
);
  localparam int P  = FRAME_WIDTH / DWIDTH;
  localparam int BW = (P > 1) ? $clog2(P) : 1;

  if (FRAME_WIDTH % DWIDTH != 0) begin : g_bad_frame_width
    $error("FRAME_WIDTH must be a multiple of DWIDTH");
  end
  if (N2 > DWIDTH + 2) begin : g_bad_n2
    $error("N2 exceeds DWIDTH+2");
  end
  if (P == 1 && N2 > DWIDTH + 2 + CRC_WIDTH) begin : g_bad_n2_single
    $error("N2 exceeds DWIDTH+2+CRC_WIDTH for single-beat frames");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 state, state_nx;
  logic [BW-1:0]          beat, beat_nx, cur;
  logic                   active, first, last;
  logic [N2-1:0]          scr, scr_nx;
  logic [CRC_WIDTH-1:0]   crc_acc, crc_nx;
  logic [DWIDTH-1:0]      dout;
  logic                   b, fb, mismatch;

  // sof always restarts at beat 0; an in-progress frame is abandoned
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    active   = bus.sof | (state == S_RUN);
    cur      = bus.sof ? '0 : beat;
    first    = active & (cur == '0);
    last     = active & (cur == BW'(P - 1));
    if (active) begin
      if (last) begin
        state_nx = S_IDLE;
      end else begin
        state_nx = S_RUN;
        beat_nx  = cur + BW'(1);
      end
    end
  end

  // Bit-serial chain, MSB first; header and CRC field bypass both descrambler and CRC
  always_comb begin
    scr_nx   = scr;
    crc_nx   = bus.sof ? '0 : crc_acc;
    dout     = '0;
    b        = 1'b0;
    fb       = 1'b0;
    if (active) begin
      for (int i = DWIDTH - 1; i >= 0; i--) begin
        b = bus.data_in[i];
        if (first && i >= DWIDTH - 2) begin
          dout[i] = b;
        end else if (last && i < CRC_WIDTH) begin
          dout[i] = 1'b0;
        end else begin
          dout[i] = b ^ scr_nx[N1-1] ^ scr_nx[N2-1];
          scr_nx  = {scr_nx[N2-2:0], b};
          fb      = b ^ crc_nx[CRC_WIDTH-1];
          crc_nx  = {crc_nx[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
      end
    end
    mismatch = crc_nx != bus.data_in[CRC_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      beat            <= '0;
      scr             <= '0;
      crc_acc         <= '0;
      bus.sof_out     <= 1'b0;
      bus.data_out    <= '0;
      bus.crc_valid   <= 1'b0;
      bus.crc_err     <= 1'b0;
      bus.frame_abort <= 1'b0;
      bus.err_cnt     <= '0;
    end else begin
      state           <= state_nx;
      beat            <= beat_nx;
      scr             <= scr_nx;
      crc_acc         <= crc_nx;
      bus.sof_out     <= bus.sof;
      bus.data_out    <= dout;
      bus.crc_valid   <= last;
      bus.crc_err     <= last & mismatch;
      bus.frame_abort <= bus.sof & (state == S_RUN);
      if (last && mismatch && bus.err_cnt != '1) begin
        bus.err_cnt <= bus.err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_rifl_rx_frame_check.sv
// tb/tb_rifl_rx_frame_check.sv - directed bench for rifl_rx_frame_check
module tb_rifl_rx_frame_check;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rifl_rx_frame_check_if #(.DWIDTH(64), .ERR_CNT_WIDTH(16)) if1 ();
  rifl_rx_frame_check_if #(.DWIDTH(64), .ERR_CNT_WIDTH(4))  if2 ();
  rifl_rx_frame_check_if #(.DWIDTH(64), .ERR_CNT_WIDTH(16)) if3 ();

  rifl_rx_frame_check u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  rifl_rx_frame_check #(.ERR_CNT_WIDTH(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  rifl_rx_frame_check #(.FRAME_WIDTH(64)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int nchk = 0;
  int nerr = 0;
  logic [32:0]  st1, st2, st3;
  logic [255:0] tx, txc, ef, ec, rnd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // TX reference: scramble plaintext payload, append CRC over scrambled bits
  task automatic build(input logic [1:0] hdr, input logic [255:0] plain, input int fw,
                       input logic [32:0] st_in, output logic [255:0] txo, output logic [255:0] expf);
    logic [32:0] s;
    logic [11:0] c;
    logic o, fbk;
    s = st_in;
    c = '0;
    txo = '0;
    expf = plain;
    expf[fw-1] = hdr[1];
    expf[fw-2] = hdr[0];
    expf[11:0] = '0;
    for (int k = fw - 3; k >= 12; k--) begin
      o      = expf[k] ^ s[12] ^ s[32];
      txo[k] = o;
      s      = {s[31:0], o};
      fbk    = o ^ c[11];
      c      = {c[10:0], 1'b0} ^ (fbk ? 12'h80F : 12'h000);
    end
    txo[fw-1] = hdr[1];
    txo[fw-2] = hdr[0];
    txo[11:0] = c;
  endtask

  task automatic absorb(inout logic [32:0] st, input logic [255:0] txi, input int fw, input int nb);
    int lo;
    lo = fw - 64 * nb;
    if (lo < 12) lo = 12;
    for (int k = fw - 3; k >= lo; k--) st = {st[31:0], txi[k]};
  endtask

  task automatic rand256(output logic [255:0] r);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
  endtask

  task automatic send1(input logic [255:0] txi, input logic [255:0] expf, input int nb,
                       input logic exp_err, input logic exp_abort, input string tag);
    for (int bt = 0; bt < nb; bt++) begin
      if1.sof     = (bt == 0);
      if1.data_in = txi[255-64*bt -: 64];
      @(posedge clk); #1;
      chk($sformatf("%s_b%0d_data", tag, bt), if1.data_out, expf[255-64*bt -: 64]);
      chk($sformatf("%s_b%0d_sof_out", tag, bt), 64'(if1.sof_out), 64'(bt == 0));
      chk($sformatf("%s_b%0d_abort", tag, bt), 64'(if1.frame_abort), 64'(bt == 0 && exp_abort));
      chk($sformatf("%s_b%0d_valid", tag, bt), 64'(if1.crc_valid), 64'(bt == 3));
      chk($sformatf("%s_b%0d_err", tag, bt), 64'(if1.crc_err), 64'(bt == 3 && exp_err));
    end
    if1.sof     = 1'b0;
    if1.data_in = '0;
  endtask

  initial begin
    st1 = '0; st2 = '0; st3 = '0;
    if2.sof = 1'b0; if2.data_in = '0;
    if3.sof = 1'b0; if3.data_in = '0;

    // Reset with random traffic, last reset cycle carries sof
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if1.sof     = (i == 2) ? 1'b1 : 1'($urandom);
      if1.data_in = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("rst_sof_out", 64'(if1.sof_out), 64'd0);
      chk("rst_data_out", if1.data_out, 64'd0);
      chk("rst_crc_valid", 64'(if1.crc_valid), 64'd0);
      chk("rst_crc_err", 64'(if1.crc_err), 64'd0);
      chk("rst_abort", 64'(if1.frame_abort), 64'd0);
      chk("rst_err_cnt", 64'(if1.err_cnt), 64'd0);
    end
    rst_n = 1'b1;
    if1.sof = 1'b0;
    if1.data_in = {$urandom, $urandom};
    @(posedge clk); #1;
    chk("idle_data_out", if1.data_out, 64'd0);
    chk("idle_crc_valid", 64'(if1.crc_valid), 64'd0);
    chk("idle_sof_out", 64'(if1.sof_out), 64'd0);

    // Header 01, all-ones payload
    build(2'b01, {256{1'b1}}, 256, st1, tx, ef);
    chk("ones_beat1_exp", ef[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
    send1(tx, ef, 4, 1'b0, 1'b0, "ones");
    absorb(st1, tx, 256, 4);
    chk("ones_err_cnt", 64'(if1.err_cnt), 64'd0);

    // Same frame with bit 40 of beat 2 flipped (frame bit 104)
    build(2'b01, {256{1'b1}}, 256, st1, tx, ef);
    txc = tx;
    txc[104] = ~txc[104];
    ec = ef;
    ec[104] = ~ec[104];
    ec[91]  = ~ec[91];
    ec[71]  = ~ec[71];
    send1(txc, ec, 4, 1'b1, 1'b0, "flip");
    absorb(st1, tx, 256, 4);
    chk("flip_err_cnt", 64'(if1.err_cnt), 64'd1);

    rand256(rnd);
    build(2'b01, rnd, 256, st1, tx, ef);
    send1(tx, ef, 4, 1'b0, 1'b0, "clean");
    absorb(st1, tx, 256, 4);

    // Early sof on beat 2: two beats of A, then B aborts it
    rand256(rnd);
    build(2'b10, rnd, 256, st1, tx, ef);
    send1(tx, ef, 2, 1'b0, 1'b0, "partA");
    absorb(st1, tx, 256, 2);
    rand256(rnd);
    build(2'b11, rnd, 256, st1, tx, ef);
    send1(tx, ef, 4, 1'b0, 1'b1, "abortB");
    absorb(st1, tx, 256, 4);
    rand256(rnd);
    build(2'b00, rnd, 256, st1, tx, ef);
    send1(tx, ef, 4, 1'b0, 1'b0, "afterC");
    absorb(st1, tx, 256, 4);
    chk("abort_err_cnt", 64'(if1.err_cnt), 64'd1);

    // 4-bit counter saturation with CRC-field corruption
    for (int f = 0; f < 20; f++) begin
      rand256(rnd);
      build(2'b10, rnd, 256, st2, tx, ef);
      txc = tx;
      txc[0] = ~txc[0];
      for (int bt = 0; bt < 4; bt++) begin
        if2.sof     = (bt == 0);
        if2.data_in = txc[255-64*bt -: 64];
        @(posedge clk); #1;
        chk($sformatf("sat_f%0d_b%0d_data", f, bt), if2.data_out, ef[255-64*bt -: 64]);
      end
      chk($sformatf("sat_f%0d_err", f), 64'(if2.crc_err), 64'd1);
      chk($sformatf("sat_f%0d_cnt", f), 64'(if2.err_cnt), 64'((f + 1 > 15) ? 15 : f + 1));
      absorb(st2, tx, 256, 4);
    end
    if2.sof = 1'b0;
    if2.data_in = '0;

    // Single-beat frames, sof every cycle
    for (int f = 0; f < 100; f++) begin
      rand256(rnd);
      build(2'($urandom), rnd, 64, st3, tx, ef);
      if3.sof     = 1'b1;
      if3.data_in = tx[63:0];
      @(posedge clk); #1;
      chk($sformatf("p1_f%0d_data", f), if3.data_out, ef[63:0]);
      chk($sformatf("p1_f%0d_valid", f), 64'(if3.crc_valid), 64'd1);
      chk($sformatf("p1_f%0d_err", f), 64'(if3.crc_err), 64'd0);
      absorb(st3, tx, 64, 1);
    end
    if3.sof = 1'b0;
    if3.data_in = '0;
    @(posedge clk); #1;
    chk("p1_idle_valid", 64'(if3.crc_valid), 64'd0);
    chk("p1_err_cnt", 64'(if3.err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
